// File: rtl/pipe_stage_reg.sv
// WIDTH-deep register pipeline with per-stage stall and flush. A stall on any
// stage freezes that stage and every younger one in the same cycle.

module pipe_stage_reg_stage #(
  parameter int HEIGHT       = 32,
  parameter int ZERO_INVALID = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic              i_prev_hold,
  input  logic [HEIGHT-1:0] i_prev_data,
  input  logic              i_prev_valid,
  output logic [HEIGHT-1:0] o_data,
  output logic              o_valid
);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      if (ZERO_INVALID != 0) o_data <= '0;
    end else if (!i_hold) begin
      // Younger neighbour frozen while we move on: take a bubble.
      if (i_prev_hold) begin
        o_valid <= 1'b0;
        o_data  <= (ZERO_INVALID != 0) ? '0 : i_prev_data;
      end else begin
        o_valid <= i_prev_valid;
        o_data  <= i_prev_data;
      end
    end
  end
endmodule

module pipe_stage_reg #(
  parameter int WIDTH        = 2,
  parameter int HEIGHT       = 32,
  parameter int ZERO_INVALID = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HEIGHT-1:0]            in,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             stall,
  input  logic [WIDTH-1:0]             flush,
  output logic                         in_ready,
  output logic [WIDTH-1:0][HEIGHT-1:0] out,
  output logic [WIDTH-1:0]             out_valid,
  output logic [$clog2(WIDTH+1)-1:0]   count
);
  localparam int CW = $clog2(WIDTH+1);

  logic [WIDTH-1:0]             w_hold;
  logic [WIDTH-1:0]             w_prev_hold;
  logic [WIDTH-1:0]             w_prev_valid;
  logic [WIDTH-1:0][HEIGHT-1:0] w_prev_data;

  // Effective hold: OR of own stall and all older stalls.
  always_comb begin
    w_hold = '0;
    w_hold[WIDTH-1] = stall[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) w_hold[i] = stall[i] | w_hold[i+1];
  end

  // Stage 0 sees the input port as its predecessor, which never holds.
  always_comb begin
    w_prev_data  = '0;
    w_prev_valid = '0;
    w_prev_hold  = '0;
    w_prev_data[0]  = in;
    w_prev_valid[0] = in_valid;
    for (int i = 1; i < WIDTH; i++) begin
      w_prev_data[i]  = out[i-1];
      w_prev_valid[i] = out_valid[i-1];
      w_prev_hold[i]  = w_hold[i-1];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    pipe_stage_reg_stage #(
      .HEIGHT      (HEIGHT),
      .ZERO_INVALID(ZERO_INVALID)
    ) u_stage (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_flush     (flush[g]),
      .i_hold      (w_hold[g]),
      .i_prev_hold (w_prev_hold[g]),
      .i_prev_data (w_prev_data[g]),
      .i_prev_valid(w_prev_valid[g]),
      .o_data      (out[g]),
      .o_valid     (out_valid[g])
    );
  end

  assign in_ready = ~w_hold[0];

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) count = count + CW'(out_valid[i]);
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (WIDTH=3, HEIGHT=8): a queue scoreboard
// checks every entry leaving stage 2, plus direct checks of bubbles/flush/reset.

module tb_pipe_stage_reg;
  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       tb_in;
  logic             tb_in_valid;
  logic [2:0]       tb_stall, tb_flush;
  logic             in_ready, nz_in_ready;
  logic [2:0][7:0]  out, nz_out;
  logic [2:0]       out_valid, nz_out_valid;
  logic [1:0]       count, nz_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(3), .HEIGHT(8), .ZERO_INVALID(1)) u_dut (
    .clk(clk), .reset(reset), .in(tb_in), .in_valid(tb_in_valid),
    .stall(tb_stall), .flush(tb_flush), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .count(count)
  );

  pipe_stage_reg #(.WIDTH(3), .HEIGHT(8), .ZERO_INVALID(0)) u_dut_nz (
    .clk(clk), .reset(reset), .in(tb_in), .in_valid(tb_in_valid),
    .stall(tb_stall), .flush(tb_flush), .in_ready(nz_in_ready),
    .out(nz_out), .out_valid(nz_out_valid), .count(nz_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entry is accepted only when no stage stalls; flush[0] kills it on capture.
  task automatic drive(input logic [7:0] d, input logic v, input logic [2:0] st,
                       input logic [2:0] fl);
    tb_in = d; tb_in_valid = v; tb_stall = st; tb_flush = fl;
    if (v && st == 3'b000 && !fl[0]) sb.push_back(d);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Stage 2 entry leaves at the coming edge when it is neither held nor flushed.
  always @(negedge clk) begin
    if (!reset && out_valid[2] && !tb_stall[2] && !tb_flush[2]) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got 0x%0h expected no output at %0t", out[2], $time);
      end else begin
        chk("sb_out2", {24'd0, out[2]}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(8'h00, 1'b0, 3'b000, 3'b000);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", out, 0);
    chk("rst_nz_data", nz_out, 0);
    tb_stall = 3'b100; #1;
    chk("rst_rdy_stalled", in_ready, 0);
    chk("rst_nz_rdy_stalled", nz_in_ready, 0);
    tb_stall = 3'b000; #1;
    chk("rst_rdy", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Stream
    drive(8'h11, 1, 3'b000, 3'b000); step;
    drive(8'h22, 1, 3'b000, 3'b000); step;
    drive(8'h33, 1, 3'b000, 3'b000); step;
    chk("str_e3_out2", out[2], 8'h11);
    chk("str_e3_count", count, 3);
    drive(8'h00, 0, 3'b000, 3'b000); step;
    chk("str_e4_out2", out[2], 8'h22);
    step;
    chk("str_e5_out2", out[2], 8'h33);
    chk("str_e5_count", count, 1);
    step;
    chk("str_empty", count, 0);

    // Stall stage 1 with a full pipe
    drive(8'hAA, 1, 3'b000, 3'b000); step;
    drive(8'hBB, 1, 3'b000, 3'b000); step;
    drive(8'hCC, 1, 3'b000, 3'b000); step;
    chk("stl_full", count, 3);
    drive(8'hDD, 1, 3'b010, 3'b000); #1;
    chk("stl_rdy", in_ready, 0);
    step;
    chk("stl_valid", out_valid, 3'b011);
    chk("stl_out2_zero", out[2], 8'h00);
    chk("stl_out1", out[1], 8'hBB);
    chk("stl_out0", out[0], 8'hCC);
    chk("stl_count", count, 2);
    chk("nz_bubble_data", nz_out[2], 8'hBB);
    chk("nz_bubble_valid", nz_out_valid[2], 0);
    chk("nz_bubble_count", nz_count, 2);
    drive(8'hDD, 1, 3'b000, 3'b000); step;

    // Flush stages 0/1 while stage 0 stalls; DD (stage 0) dies, CC moves to stage 2
    drive(8'hEE, 1, 3'b001, 3'b011); #1;
    void'(sb.pop_back());
    chk("fl_rdy", in_ready, 0);
    step;
    chk("fl_valid", out_valid, 3'b100);
    chk("fl_out2", out[2], 8'hCC);
    chk("fl_out1", out[1], 8'h00);
    chk("fl_out0", out[0], 8'h00);
    drive(8'h00, 0, 3'b000, 3'b000); step; step;
    chk("fl_drained", count, 0);

    // Asynchronous reset between edges
    drive(8'h51, 1, 3'b000, 3'b000); step;
    drive(8'h52, 1, 3'b000, 3'b000); step;
    drive(8'h53, 1, 3'b000, 3'b000); step;
    drive(8'h00, 0, 3'b000, 3'b000);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_data", out, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #4;
    drive(8'h77, 1, 3'b000, 3'b000); step;
    drive(8'h00, 0, 3'b000, 3'b000); step; step;
    chk("ar_first_out2", out[2], 8'h77);
    chk("ar_first_valid", out_valid, 3'b100);
    step;
    chk("ar_drained", count, 0);

    // Backpressure: stall[2] for 4 cycles, source keeps presenting
    begin
      logic [7:0] v;
      logic [2:0] st;
      v = 8'h80;
      for (int c = 0; c < 12; c++) begin
        st = (c >= 3 && c < 7) ? 3'b100 : 3'b000;
        drive(v, 1, st, 3'b000); #1;
        chk("bp_rdy", in_ready, (st == 3'b000));
        step;
        if (st == 3'b000) v = v + 8'd1;
      end
    end
    drive(8'h00, 0, 3'b000, 3'b000);
    repeat (4) step;
    chk("bp_drained", count, 0);
    chk("sb_leftover", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 2: number of pipeline stages (1..16); stage 0 is youngest, stage WIDTH-1 is oldest.
REQ-002 Parameter HEIGHT, default 32: data bits per stage (1..64).
REQ-003 Parameter ZERO_INVALID, default 1: 1 = bubbled/flushed stages load all-zero data; 0 = data field is left as described in REQ-016.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in  input  HEIGHT  data entering stage 0.
REQ-007 in_valid  input  1  in carries a live entry.
REQ-008 stall  input  WIDTH  stall[i] requests stage i to hold.
REQ-009 flush  input  WIDTH  flush[i] kills the entry in stage i.
REQ-010 in_ready  output  1  stage 0 accepts in this cycle.
REQ-011 out  output  [WIDTH-1:0][HEIGHT]  registered data of every stage.
REQ-012 out_valid  output  WIDTH  registered valid bit of every stage.
REQ-013 count  output  $clog2(WIDTH+1)  number of set out_valid bits.

Function
REQ-014 Effective hold h[i] = OR of stall[i..WIDTH-1]; an older stall freezes every younger stage in the same cycle.
REQ-015 in_ready = ~h[0], combinational; with in_valid=1 and in_ready=0 the entry is not captured, and the source keeps presenting it.
REQ-016 Stage update per rising edge, in this priority:
- flush[i]=1: valid[i]<=0; data[i]<=0 when ZERO_INVALID=1, otherwise data unchanged.
- else h[i]=1: stage i holds data and valid.
- else i=0: data[0]<=in, valid[0]<=in_valid.
- else h[i-1]=1: bubble; valid[i]<=0; data[i]<=0 when ZERO_INVALID=1, otherwise data[i]<=data[i-1].
- else data[i]<=data[i-1], valid[i]<=valid[i-1].
REQ-017 Flush overrides hold in the same cycle; a stage that is both flushed and stalled holds a bubble.
REQ-018 Flush of stage i does not affect stage i+1; a flush covering several stages requires several flush bits.
REQ-019 Latency: with no stall or flush, in appears on out[k] k+1 edges after capture and on out[WIDTH-1] WIDTH edges after capture.
REQ-020 Data of an invalid stage is don't-care to consumers; with ZERO_INVALID=1 it is all-zero.
REQ-021 count is combinational popcount of out_valid, range 0..WIDTH.
REQ-022 With WIDTH=1: h[0]=stall[0], and no bubble path exists.
REQ-023 Entries never reorder, duplicate or vanish except through flush.

Reset
REQ-024 While reset=1: all data=0, all out_valid=0, count=0 immediately, with no clock edge required.
REQ-025 A reset asserted mid-stall or mid-flush discards all entries; the first edge after release follows REQ-016 with empty stages.
REQ-026 in_ready reflects stall even during reset.

Verification (WIDTH=3, HEIGHT=8, ZERO_INVALID=1 unless stated)
REQ-027 Stream: in=0x11,0x22,0x33 valid on consecutive edges, no stall -> out[2]=0x11 at edge 3, 0x22 at edge 4, 0x33 at edge 5; count reaches 3.
REQ-028 Stall: stall=3'b010 for one cycle with all stages full (A,B,C oldest) -> stages 0 and 1 hold, stage 2 gets a bubble (valid=0, data=0x00), in_ready=0, count drops 3->2.
REQ-029 Flush: flush=3'b011 together with stall=3'b001 -> stages 0 and 1 become invalid and zero, stage 2 advances normally, in_ready=0.
REQ-030 Bubble passthrough, ZERO_INVALID=0: repeat REQ-028 -> stage 2 data equals the stage 1 data, valid=0.
REQ-031 Async reset: assert reset between edges with 3 valid entries -> out_valid=000, count=0, out all zero before the next edge; first input after release appears on out[2] 3 edges later.
REQ-032 Backpressure: stall[2] held 4 cycles with in_valid=1 throughout -> exactly the entries accepted while in_ready=1 emerge, in order, with no duplicates.
